// File: rtl/lsu_mem_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_mem_initiator                                            |
// | Description : RV64 load/store initiator driving a doubleword data memory.  |
// |               Loads extract and extend a lane. Sub-doubleword stores use   |
// |               read-modify-write. Optional statistics counters are enabled  |
// |               by defining LSU_STATS_EN.                                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module lsu_mem_initiator #(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W    = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [63:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [63:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [63:0]       mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [63:0]       mem_read_data,
   output logic [31:0]       stat_loads,
   output logic [31:0]       stat_stores,
   output logic [31:0]       stat_errs
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RMW_RD = 3'd2,
      WRITE  = 3'd3,
      RESP   = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] c_MEM_LIMIT = ADDR_W'(MEM_BYTES);

   state_t      r_state;
   state_t      w_next_state;
   logic        r_store;
   logic [2:0]  r_funct3;
   logic [2:0]  r_offset;
   logic [63:0] r_wdata;

   logic        w_misaligned;
   logic        w_err;
   logic [5:0]  w_shamt;
   logic [63:0] w_shifted;
   logic [63:0] w_load_data;
   logic [63:0] w_size_mask;
   logic [63:0] w_lane_mask;
   logic [63:0] w_merged;

   // Request checks evaluated combinationally while IDLE.
   always_comb begin
      w_misaligned = 1'b0;
      case (req_funct3[1:0])
         2'b01:   w_misaligned = req_addr[0];
         2'b10:   w_misaligned = |req_addr[1:0];
         2'b11:   w_misaligned = |req_addr[2:0];
         default: w_misaligned = 1'b0;
      endcase
      w_err = (req_addr >= c_MEM_LIMIT) | w_misaligned
            | (req_funct3 == 3'b111) | (req_store & req_funct3[2]);
   end

   // Lane extraction for loads and lane merge for read-modify-write stores.
   always_comb begin
      w_shamt     = {r_offset, 3'b000};
      w_shifted   = mem_read_data >> w_shamt;
      w_load_data = 64'd0;
      case (r_funct3)
         3'b000:  w_load_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
         3'b001:  w_load_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
         3'b010:  w_load_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
         3'b011:  w_load_data = w_shifted;
         3'b100:  w_load_data = {56'd0, w_shifted[7:0]};
         3'b101:  w_load_data = {48'd0, w_shifted[15:0]};
         3'b110:  w_load_data = {32'd0, w_shifted[31:0]};
         default: w_load_data = 64'd0;
      endcase
      w_size_mask = 64'd0;
      case (r_funct3[1:0])
         2'b00:   w_size_mask = 64'h0000_0000_0000_00FF;
         2'b01:   w_size_mask = 64'h0000_0000_0000_FFFF;
         2'b10:   w_size_mask = 64'h0000_0000_FFFF_FFFF;
         default: w_size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      w_lane_mask = w_size_mask << w_shamt;
      w_merged    = (mem_read_data & ~w_lane_mask) | ((r_wdata & w_size_mask) << w_shamt);
   end

   // State register; async reset drops the memory strobes immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state and strobe decode, strobes come from the state register only.
   always_comb begin
      w_next_state = r_state;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_err)                      w_next_state = RESP;
               else if (!req_store)            w_next_state = LOAD;
               else if (req_funct3[1:0] == 2'b11) w_next_state = WRITE;
               else                            w_next_state = RMW_RD;
            end
         end
         LOAD: begin
            mem_read     = 1'b1;
            w_next_state = RESP;
         end
         RMW_RD: begin
            mem_read     = 1'b1;
            w_next_state = WRITE;
         end
         WRITE: begin
            mem_write    = 1'b1;
            w_next_state = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Request capture, load result capture and merged store data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_store        <= 1'b0;
         r_funct3       <= 3'd0;
         r_offset       <= 3'd0;
         r_wdata        <= 64'd0;
         mem_address    <= '0;
         mem_write_data <= 64'd0;
         resp_rdata     <= 64'd0;
         resp_err       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_store     <= req_store;
                  r_funct3    <= req_funct3;
                  r_offset    <= req_addr[2:0];
                  r_wdata     <= req_wdata;
                  mem_address <= {req_addr[ADDR_W-1:3], 3'b000};
                  resp_rdata  <= 64'd0;
                  resp_err    <= w_err;
                  if (req_store && (req_funct3[1:0] == 2'b11))
                     mem_write_data <= req_wdata;
               end
            end
            LOAD:    resp_rdata     <= w_load_data;
            RMW_RD:  mem_write_data <= w_merged;
            default: ;
         endcase
      end
   end

`ifdef LSU_STATS_EN
   // Saturating counters bump when a response is consumed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_loads  <= 32'd0;
         stat_stores <= 32'd0;
         stat_errs   <= 32'd0;
      end else if (resp_valid && resp_ready) begin
         if (resp_err) begin
            if (stat_errs != 32'hFFFF_FFFF) stat_errs <= stat_errs + 32'd1;
         end else if (r_store) begin
            if (stat_stores != 32'hFFFF_FFFF) stat_stores <= stat_stores + 32'd1;
         end else begin
            if (stat_loads != 32'hFFFF_FFFF) stat_loads <= stat_loads + 32'd1;
         end
      end
   end
`else
   assign stat_loads  = 32'd0;
   assign stat_stores = 32'd0;
   assign stat_errs   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lsu_mem_initiator                                         |
// | Description : Self-checking bench for lsu_mem_initiator with a byte-level  |
// |               reference memory and a doubleword data_memory model.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_lsu_mem_initiator;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [63:0] req_addr = 64'd0;
   logic [63:0] req_wdata = 64'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic [63:0] mem_address;
   logic [63:0] mem_write_data;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] mem_read_data;
   logic [31:0] stat_loads, stat_stores, stat_errs;

   lsu_mem_initiator #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
      .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
   );

   always #5 clk = ~clk;

   // data_memory model: combinational read, write on the rising edge.
   logic [63:0] mem [0:127];
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic [63:0] last_wr_addr = 64'd0;
   assign mem_read_data = mem[mem_address[9:3]];
   always @(posedge clk) begin
      if (mem_read) rd_cnt++;
      if (mem_write) begin
         mem[mem_address[9:3]] <= mem_write_data;
         wr_cnt++;
         last_wr_addr = mem_address;
      end
   end

   // Reference: plain byte array following the architectural rules.
   logic [7:0] ref_mem [0:1023];
   int checks = 0;
   int errors = 0;
   int n_loads = 0, n_stores = 0, n_errs = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%h expected=0x%h", nm, act, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic ref_err(input logic st, input logic [2:0] f3, input logic [63:0] a);
      if (a >= 64'd1024) return 1'b1;
      if (f3 == 3'b111) return 1'b1;
      if (st && f3[2]) return 1'b1;
      if ((a % 64'(size_of(f3))) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
      int n;
      logic [63:0] v;
      n = size_of(f3);
      v = 64'd0;
      for (int i = 0; i < n; i++) v = v | (64'(ref_mem[a + 64'(i)]) << (8 * i));
      if (!f3[2] && n < 8 && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      return v;
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
      for (int i = 0; i < size_of(f3); i++) ref_mem[a + 64'(i)] = wd[8 * i +: 8];
   endtask

   function automatic int ref_lat(input logic st, input logic [2:0] f3, input logic e);
      if (e) return 1;
      if (!st || f3[1:0] == 2'b11) return 2;
      return 3;
   endfunction

   task automatic check_stats(input string nm);
`ifdef LSU_STATS_EN
      chk({nm, "_loads"},  64'(stat_loads),  64'(n_loads));
      chk({nm, "_stores"}, 64'(stat_stores), 64'(n_stores));
      chk({nm, "_errs"},   64'(stat_errs),   64'(n_errs));
`else
      chk({nm, "_loads"},  64'(stat_loads),  64'd0);
      chk({nm, "_stores"}, 64'(stat_stores), 64'd0);
      chk({nm, "_errs"},   64'(stat_errs),   64'd0);
`endif
   endtask

   // One full transaction: accept, wait for response, check, consume.
   task automatic run_req(input string nm, input logic st, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] exp_rd, input logic exp_err, input int exp_lat);
      int lat, rd0, wr0, exp_r, exp_w;
      logic got;
      @(negedge clk);
      chk({nm, "_req_ready"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      rd0 = rd_cnt; wr0 = wr_cnt;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; got = 1'b0;
      while (!got && lat < 10) begin
         @(negedge clk);
         lat++;
         if (resp_valid) got = 1'b1;
      end
      chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({nm, "_rdata"}, resp_rdata, exp_rd);
      chk({nm, "_err"}, 64'(resp_err), 64'(exp_err));
      exp_r = exp_err ? 0 : (!st ? 1 : (f3[1:0] == 2'b11 ? 0 : 1));
      exp_w = (!exp_err && st) ? 1 : 0;
      chk({nm, "_reads"}, 64'(rd_cnt - rd0), 64'(exp_r));
      chk({nm, "_writes"}, 64'(wr_cnt - wr0), 64'(exp_w));
      if (exp_w == 1) chk({nm, "_wr_addr"}, last_wr_addr, {a[63:3], 3'b000});
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      if (exp_err) n_errs++;
      else if (st) begin n_stores++; ref_store(f3, a, wd); end
      else n_loads++;
   endtask

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [63:0] addr;
      logic [63:0] wd;
      logic [63:0] rd;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [63:0] dw, a, wd;
      logic [2:0]  f3;
      logic        st, e;
      int          bad;

      vecs[0]  = '{1'b0, 3'b000, 64'h17,  64'd0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 2};
      vecs[1]  = '{1'b0, 3'b100, 64'h17,  64'd0, 64'h0000_0000_0000_0088, 1'b0, 2};
      vecs[2]  = '{1'b0, 3'b001, 64'h16,  64'd0, 64'hFFFF_FFFF_FFFF_8877, 1'b0, 2};
      vecs[3]  = '{1'b0, 3'b110, 64'h14,  64'd0, 64'h0000_0000_8877_6655, 1'b0, 2};
      vecs[4]  = '{1'b1, 3'b001, 64'h12,  64'h1111_2222_3333_ABCD, 64'd0, 1'b0, 3};
      vecs[5]  = '{1'b0, 3'b011, 64'h10,  64'd0, 64'h8877_6655_ABCD_2211, 1'b0, 2};
      vecs[6]  = '{1'b1, 3'b011, 64'h3F8, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 2};
      vecs[7]  = '{1'b0, 3'b011, 64'h3F8, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 2};
      vecs[8]  = '{1'b0, 3'b010, 64'h11,  64'd0, 64'd0, 1'b1, 1};
      vecs[9]  = '{1'b0, 3'b000, 64'h400, 64'd0, 64'd0, 1'b1, 1};
      vecs[10] = '{1'b1, 3'b100, 64'h20,  64'h55, 64'd0, 1'b1, 1};
      vecs[11] = '{1'b0, 3'b111, 64'h20,  64'd0, 64'd0, 1'b1, 1};

      for (int i = 0; i < 128; i++) begin
         dw = (i == 2) ? 64'h8877_6655_4433_2211 : {$urandom, $urandom};
         mem[i] = dw;
         for (int b = 0; b < 8; b++) ref_mem[i * 8 + b] = dw[8 * b +: 8];
      end

      // Outputs while reset is held.
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
      chk("rst_mem_address", mem_address, 64'd0);
      chk("rst_mem_wdata", mem_write_data, 64'd0);
      chk("rst_rdata_err", resp_rdata | 64'(resp_err), 64'd0);
      check_stats("rst_stats");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i])
         run_req($sformatf("vec%0d", i), vecs[i].st, vecs[i].f3, vecs[i].addr,
                 vecs[i].wd, vecs[i].rd, vecs[i].err, vecs[i].lat);

      // Randomised traffic against the byte-level model.
      for (int k = 0; k < 150; k++) begin
         st = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) a = 64'd1024 + 64'($urandom_range(0, 5000));
         else begin
            a = 64'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) < 7) a = a & ~(64'(size_of(f3)) - 64'd1);
         end
         wd = {$urandom, $urandom};
         e = ref_err(st, f3, a);
         run_req($sformatf("rnd%0d", k), st, f3, a, wd,
                 (e || st) ? 64'd0 : ref_load(f3, a), e, ref_lat(st, f3, e));
      end

      bad = 0;
      for (int i = 0; i < 128; i++)
         for (int b = 0; b < 8; b++)
            if (mem[i][8 * b +: 8] !== ref_mem[i * 8 + b]) bad++;
      chk("mem_image_bad_bytes", 64'(bad), 64'd0);

      // Back-pressure: response held for three cycles, then consumed.
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b011; req_addr = 64'h3F8;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("bp%0d_valid", c), 64'(resp_valid), 64'd1);
         chk($sformatf("bp%0d_rdata", c), resp_rdata, 64'h0123_4567_89AB_CDEF);
         chk($sformatf("bp%0d_req_ready", c), 64'(req_ready), 64'd0);
         @(negedge clk);
      end
      // Offer a new request during consumption; it must not be taken then.
      resp_ready = 1'b1; req_valid = 1'b1; req_funct3 = 3'b011; req_addr = 64'h10;
      @(posedge clk);
      #1 resp_ready = 1'b0; req_valid = 1'b0;
      n_loads++;
      chk("bp_idle_req_ready", 64'(req_ready), 64'd1);
      chk("bp_idle_resp_valid", 64'(resp_valid), 64'd0);
      chk("bp_idle_no_read", 64'(mem_read), 64'd0);
      check_stats("bp_stats");

      // Reset while the SB read-modify-write read is in flight.
      wr_cnt = 0;
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 64'h33; req_wdata = 64'hAA;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rmw_read_active", 64'(mem_read), 64'd1);
      #1 reset = 1'b1;
      #1;
      chk("rmw_rst_read", 64'(mem_read), 64'd0);
      chk("rmw_rst_write", 64'(mem_write), 64'd0);
      chk("rmw_rst_ready", 64'(req_ready), 64'd1);
      chk("rmw_rst_valid", 64'(resp_valid), 64'd0);
      chk("rmw_rst_addr", mem_address, 64'd0);
      chk("rmw_rst_wdata", mem_write_data, 64'd0);
      chk("rmw_rst_rdata", resp_rdata | 64'(resp_err), 64'd0);
      n_loads = 0; n_stores = 0; n_errs = 0;
      check_stats("rmw_rst_stats");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rmw_rst_no_write", 64'(wr_cnt), 64'd0);
      chk("rmw_rst_mem", mem[6], {ref_mem[55], ref_mem[54], ref_mem[53], ref_mem[52],
                                  ref_mem[51], ref_mem[50], ref_mem[49], ref_mem[48]});

      // Statistics: two loads, one store, one error.
      run_req("st_lb", 1'b0, 3'b000, 64'h10, 64'd0, ref_load(3'b000, 64'h10), 1'b0, 2);
      run_req("st_ld", 1'b0, 3'b011, 64'h18, 64'd0, ref_load(3'b011, 64'h18), 1'b0, 2);
      run_req("st_sd", 1'b1, 3'b011, 64'h20, 64'hDEAD_BEEF_0000_1234, 64'd0, 1'b0, 2);
      run_req("st_err", 1'b0, 3'b010, 64'h11, 64'd0, 64'd0, 1'b1, 1);
      @(negedge clk);
`ifdef LSU_STATS_EN
      chk("stats_final", {stat_loads[15:0], stat_stores[15:0], stat_errs[15:0], 16'd0},
          {16'd2, 16'd1, 16'd1, 16'd0});
`else
      chk("stats_final", {stat_loads[15:0], stat_stores[15:0], stat_errs[15:0], 16'd0}, 64'd0);
`endif
      check_stats("end_stats");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator sitting between the execute stage and data_memory.
- Accepts one RV64 load/store request at a time over a valid/ready handshake.
- Drives data_memory's doubleword port (address, write_data, mem_read, mem_write) and returns the extracted, extended load data or a store completion with an error flag.
- Sub-doubleword stores use read-modify-write, because the memory port only writes whole doublewords.

Parameters:
- MEM_BYTES, 1024, memory size in bytes; must be a multiple of 8. Valid addresses are 0..MEM_BYTES-1.
- ADDR_W, 64, address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  initiator can accept a request.
- req_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  64  store data, right-justified.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  64  load result; 0 for stores and errors.
- resp_err  output  1  request rejected: misaligned, out of range, or illegal funct3.
- mem_address  output  ADDR_W  doubleword-aligned address to data_memory.
- mem_write_data  output  64  doubleword to write.
- mem_read  output  1  read strobe; data_memory returns read data combinationally in the same cycle.
- mem_write  output  1  write strobe; data_memory commits on the rising edge.
- mem_read_data  input  64  doubleword from data_memory, little-endian.
- stat_loads, stat_stores, stat_errs  output  32 each  statistics counters (see Optional Feature).

Behaviour:
- Reset values: state IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0, all counters 0.
- Reset asserted mid-operation forces IDLE immediately. mem_read and mem_write drop asynchronously. An in-flight RMW store is abandoned with no write.
- mem_read and mem_write are decoded from the state register only. mem_address and mem_write_data are registered. No combinational path from req_* to mem_*.
- Aligned base = {req_addr[ADDR_W-1:3], 3'b000}; lane offset = req_addr[2:0].
- Error checks, all performed in IDLE at accept:
  - Error if req_addr >= MEM_BYTES.
  - Error if H is not 2-byte aligned, W is not 4-byte aligned, or D is not 8-byte aligned.
  - Error if funct3 = 111, or funct3[2] = 1 on a store.
  - On error: go to RESP with resp_err=1 and resp_rdata=0. No mem strobe is ever asserted.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch request fields and base; go to LOAD (load), WRITE (D store, merged = wdata), RMW_RD (B/H/W store), or RESP (error).
- LOAD (1 cycle): mem_read=1. At the clock edge, capture mem_read_data >> (8*offset), truncate to size, sign-extend (B/H/W) or zero-extend (BU/HU/WU/D) into resp_rdata. Go to RESP.
- RMW_RD (1 cycle): mem_read=1. At the clock edge, merged = mem_read_data with the size-byte lanes starting at offset replaced by the low bytes of wdata. Go to WRITE.
- WRITE (1 cycle): mem_write=1, mem_write_data=merged. Go to RESP.
- RESP:
  - resp_valid=1, req_ready=0.
  - resp_rdata and resp_err are held stable until resp_ready=1, then go to IDLE.
  - No request is accepted in the same cycle as response consumption.
- Latency from accept edge to resp_valid high:
  - Error: 1 cycle.
  - Load: 2 cycles.
  - D store: 2 cycles.
  - Sub-doubleword store: 3 cycles.
- Exactly one mem_write pulse per successful store; zero for loads and errors.

Optional Feature:
- Macro LSU_STATS_EN.
- When defined: stat_loads, stat_stores, stat_errs are 32-bit saturating counters. Each increments once in the cycle its response is consumed (resp_valid && resp_ready). Errors count only in stat_errs. Counters hold at 0xFFFFFFFF on saturation. Reset clears them.
- When not defined: the ports remain and are tied to 0; no counter flops are synthesized.

Test Plan:
- Memory 0x10..0x17 = 0x8877665544332211. LB 0x17 -> resp_rdata=0xFFFFFFFFFFFFFF88, err=0. LBU 0x17 -> 0x0000000000000088. LH 0x16 -> 0xFFFFFFFFFFFF8877. LWU 0x14 -> 0x0000000088776655.
- Same data, SH wdata=0x...ABCD at 0x12 -> one mem_read then one mem_write at address 0x10 with data 0x88776655ABCD2211. Response 3 cycles after accept, err=0.
- SD 0x0123456789ABCDEF at 0x3F8 -> no mem_read; one mem_write at 0x3F8. LD 0x3F8 returns the same value.
- Error cases, each giving resp_err=1 one cycle after accept with no mem strobes: LW at 0x11 (misaligned); LB at 0x400 (out of range); store with funct3=100 (illegal).
- LD issued with resp_ready held 0 for 3 cycles -> resp_valid and resp_rdata stable, req_ready=0. Accept on the 4th cycle -> IDLE, req_ready=1.
- Reset asserted while in RMW_RD for an SB -> mem_read=0 immediately, no mem_write ever, memory unchanged, all outputs at reset values.
- With LSU_STATS_EN: 2 loads, 1 store, 1 error -> counters read 2/1/1. Without the macro -> all three read 0.
